// File: rtl/id_fetch_queue_pkg.sv
// Shared definitions for the IF->ID fetch queue: default widths and the
// width of the flattened {valid, pc, inst} bus handed to decode.
package id_fetch_queue_pkg;

  localparam int FQ_DEF_DEPTH  = 4;
  localparam int FQ_DEF_PC_W   = 32;
  localparam int FQ_DEF_INST_W = 32;

  function automatic int fq_to_id_wd(input int pc_w, input int inst_w);
    return pc_w + inst_w + 1;
  endfunction

  localparam int FQ_TO_ID_WD = fq_to_id_wd(FQ_DEF_PC_W, FQ_DEF_INST_W);

endpackage

// File: rtl/id_fetch_queue_if.sv
// Fetch-side and decode-side handshake of the fetch queue.
// The slave modport is the queue itself; master is the surrounding pipeline.
interface id_fetch_queue_if
  import id_fetch_queue_pkg::*;
#(
  parameter int PC_W   = FQ_DEF_PC_W,
  parameter int INST_W = FQ_DEF_INST_W
) ();

  logic              flush;
  logic              req_valid;
  logic [PC_W-1:0]   req_pc;
  logic [INST_W-1:0] inst_sram_rdata;
  logic              stallreq;
  logic              out_ready;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;

  modport master (
    output flush, req_valid, req_pc, inst_sram_rdata, out_ready,
    input  stallreq, out_valid, out_pc, out_inst
  );

  modport slave (
    input  flush, req_valid, req_pc, inst_sram_rdata, out_ready,
    output stallreq, out_valid, out_pc, out_inst
  );

endinterface

// File: rtl/id_fetch_queue_fq_ram.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module fq_ram
  import id_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEF_DEPTH,
  parameter int WIDTH = FQ_DEF_PC_W + FQ_DEF_INST_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/id_fetch_queue.sv
// Fetch queue between IF and ID: pairs each issued PC with the instruction
// returned one cycle later, buffers the pair, and presents it to decode.
module id_fetch_queue
  import id_fetch_queue_pkg::*;
#(
  parameter int DEPTH     = FQ_DEF_DEPTH,
  parameter int PC_W      = FQ_DEF_PC_W,
  parameter int INST_W    = FQ_DEF_INST_W,
  parameter int BYPASS    = 1,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  id_fetch_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int ENT_W = PC_W + INST_W;
  localparam int BUS_W = fq_to_id_wd(PC_W, INST_W);

  logic              pend_valid;
  logic [PC_W-1:0]   pend_pc;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [ENT_W-1:0]  head_ent;
  logic [BUS_W-1:0]  fq_to_id;
  logic              q_empty;
  logic              q_full;
  logic              pair_valid;
  logic              bypass;
  logic              push;
  logic              pop;

  assign q_empty    = (cnt == '0);
  assign q_full     = (cnt == CNT_W'(DEPTH));
  assign pair_valid = pend_valid & ~bus.flush;
  assign bypass     = (BYPASS != 0) & q_empty & bus.out_ready & pair_valid;
  assign pop        = ~q_empty & bus.out_ready & ~bus.flush;
  // A full queue only takes the new pair if the head leaves in the same cycle.
  assign push       = pair_valid & ~bypass & (~q_full | pop);

  fq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fq_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({pend_pc, bus.inst_sram_rdata}),
    .raddr (rd_ptr),
    .rdata (head_ent)
  );

  always_comb begin
    fq_to_id = '0;
    if (!bus.flush) begin
      if (!q_empty)    fq_to_id = {1'b1, head_ent};
      else if (bypass) fq_to_id = {1'b1, pend_pc, bus.inst_sram_rdata};
    end
  end

  assign bus.out_valid = fq_to_id[BUS_W-1];
  assign bus.out_pc    = fq_to_id[ENT_W-1 -: PC_W];
  assign bus.out_inst  = fq_to_id[INST_W-1:0];

  // Held high through reset so IF cannot issue into a queue that is clearing.
  assign bus.stallreq  = ~rst | ((cnt + CNT_W'(pend_valid)) >= CNT_W'(AFULL_LVL));
  assign count         = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
    end else if (bus.flush) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
    end else begin
      pend_valid <= bus.req_valid;
      if (bus.req_valid) pend_pc <= bus.req_pc;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: doc/id_fetch_queue.md
ID_FETCH_QUEUE -- requirements
Module: id_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter PC_W, default 32, PC width; INST_W, default 32, instruction width.
REQ-003 Parameter BYPASS, default 1, 1 = empty-queue combinational pass-through, 0 = always registered.
REQ-004 Parameter AFULL_LVL, default DEPTH-2, almost-full threshold in entries.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-low.
REQ-007 flush  input  1  discard all queued and pending fetches this cycle.
REQ-008 req_valid  input  1  IF issued a fetch this cycle; PC on req_pc.
REQ-009 req_pc  input  PC_W  PC of the issued fetch.
REQ-010 inst_sram_rdata  input  INST_W  instruction returned one cycle after its req.
REQ-011 out_ready  input  1  decode accepts the head entry this cycle.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_pc  output  PC_W  head PC.
REQ-014 out_inst  output  INST_W  head instruction.
REQ-015 stallreq  output  1  IF must not issue req_valid next cycle.
REQ-016 count  output  $clog2(DEPTH)+1  occupied entries, pending fetch excluded.

Function
REQ-017 A req_valid at cycle t SHALL latch req_pc into a pending slot; inst_sram_rdata at t+1 SHALL pair with it.
REQ-018 A paired entry SHALL be written at the t+1 edge, unless bypassed (REQ-020).
REQ-019 Pairing SHALL preserve issue order; a pending slot and a new req in the same cycle are both legal.
REQ-020 BYPASS=1, count==0, out_ready=1: pairing cycle SHALL drive out_valid=1 with pc/inst directly; nothing written.
REQ-021 BYPASS=0: minimum latency req_valid to out_valid SHALL be 2 cycles.
REQ-022 Pop SHALL occur when out_valid && out_ready; head advances at that edge.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including at count==DEPTH.
REQ-024 Pointers SHALL wrap modulo DEPTH; full is count==DEPTH, empty is count==0.
REQ-025 stallreq SHALL be 1 when count + pending >= AFULL_LVL, guaranteeing no overflow.
REQ-026 A push at count==DEPTH without a pop SHALL be dropped; count unchanged.
REQ-027 flush SHALL, at the next edge, set count=0, clear pending, reset pointers.
REQ-028 In the flush cycle, out_valid SHALL be 0 and a same-cycle req_valid SHALL be discarded.
REQ-029 out_pc/out_inst SHALL be zero when out_valid=0.

Reset
REQ-030 rst low SHALL asynchronously clear pointers, count, and pending slot.
REQ-031 During reset, out_valid=0, out_pc=0, out_inst=0, stallreq=1, count=0.
REQ-032 stallreq SHALL drop in the first cycle after rst deasserts.
REQ-033 Storage array contents need not be reset.
REQ-034 Reset asserted mid-operation SHALL lose all entries with no partial pop.

Structure
REQ-035 The shared defines header SHALL hold the FQ_TO_ID_WD bus width (PC_W+INST_W+1).
REQ-036 Storage SHALL be one sub-module, fq_ram: DEPTH x (PC_W+INST_W), one write port, one async read port.
REQ-037 Pending slot, pointers, and count SHALL live in id_fetch_queue.

Verification
REQ-038 BYPASS=1, empty, out_ready=1; req pc=0xBFC00000, rdata=0x3C08BFAF next cycle -> out_valid same cycle as rdata, count stays 0.
REQ-039 DEPTH=4, out_ready=0, reqs ignoring stallreq: stallreq=1 at count+pending>=2; 5th push dropped; count=4.
REQ-040 Full queue with push and pop in one cycle -> count=4, head = entry 2, order preserved through a pointer wrap.
REQ-041 3 entries plus pending, flush=1 with req_valid=1 -> next cycle count=0, out_valid=0, late rdata discarded.
REQ-042 rst low for one cycle mid-stream at count=2 -> outputs immediately 0, stallreq=1; after release, first new req emerges correctly.
REQ-043 BYPASS=0, 8 back-to-back reqs, out_ready toggling 1/0 -> all 8 PCs emerge in order, none duplicated.
